// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: PCSrc codes, PC vectors and the fetch FSM
// encoding used by both the decoder and pc_fetch_unit.
package mips_pkg;

  localparam logic [2:0] PCSRC_NORMAL = 3'b000;
  localparam logic [2:0] PCSRC_BRANCH = 3'b001;
  localparam logic [2:0] PCSRC_JUMP   = 3'b010;
  localparam logic [2:0] PCSRC_JR     = 3'b011;
  localparam logic [2:0] PCSRC_ILLOP  = 3'b100;
  localparam logic [2:0] PCSRC_XADR   = 3'b101;

  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VECTOR = 32'h8000_0004;
  localparam logic [31:0] XADR_VECTOR  = 32'h8000_0008;

  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

  // The kernel bit is never carried into: the low 31 bits wrap on their own.
  function automatic logic [31:0] pc_inc4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for pc_fetch_unit: PCSrc mux with kernel-bit protection
// and the jr/jalr alignment check. Purely combinational.
module pc_next_sel
  import mips_pkg::*;
#(
  parameter logic [31:0] ILLOP_PC = ILLOP_VECTOR,
  parameter logic [31:0] XADR_PC  = XADR_VECTOR
) (
  input  logic [3:0]  pc_hi,
  input  logic [31:0] pc_plus4,
  input  logic [2:0]  pcsrc,
  input  logic        branch_taken,
  input  logic [31:0] conba,
  input  logic [25:0] jt,
  input  logic [31:0] databus_a,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] branch_pc;

  always_comb begin
    // Branch targets keep the current privilege level.
    branch_pc     = conba;
    branch_pc[31] = pc_hi[3];
    target        = XADR_PC;
    case (pcsrc)
      PCSRC_NORMAL: target = pc_plus4;
      PCSRC_BRANCH: target = branch_taken ? branch_pc : pc_plus4;
      PCSRC_JUMP:   target = {pc_hi, jt, 2'b00};
      PCSRC_JR:     target = databus_a;
      PCSRC_ILLOP:  target = ILLOP_PC;
      default:      target = XADR_PC;
    endcase
  end

  assign misaligned = (pcsrc == PCSRC_JR) && (databus_a[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC owner and instruction fetcher: IDLE -> FETCH (req/ack) -> ISSUE (retire).
// Define PC_FETCH_TIMEOUT_EN to add a fetch watchdog that traps to XADR_PC.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter logic [31:0] ILLOP_PC = ILLOP_VECTOR,
  parameter logic [31:0] XADR_PC  = XADR_VECTOR
`ifdef PC_FETCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  PCSrc,
  input  logic        BranchTaken,
  input  logic [31:0] ConBA,
  input  logic [25:0] JT,
  input  logic [31:0] DatabusA,
  input  logic        retire,
  input  logic        IRQ,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic [31:0] EPC,
  output logic        irq_taken,
  output logic        addr_err
);

  fetch_state_t state_reg;
  logic [31:0]  pc_reg;
  logic [31:0]  epc_reg;
  logic [31:0]  instruction_reg;
  logic         imem_req_reg;
  logic         instr_valid_reg;
  logic         irq_taken_reg;
  logic         addr_err_reg;
  logic         irq_pending_reg;

  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         misaligned;
  logic         retire_now;
  logic         take_irq;

  assign pc_plus4 = pc_inc4(pc_reg);

  pc_next_sel #(
    .ILLOP_PC (ILLOP_PC),
    .XADR_PC  (XADR_PC)
  ) u_next_sel (
    .pc_hi        (pc_reg[31:28]),
    .pc_plus4     (pc_plus4),
    .pcsrc        (PCSrc),
    .branch_taken (BranchTaken),
    .conba        (ConBA),
    .jt           (JT),
    .databus_a    (DatabusA),
    .target       (target),
    .misaligned   (misaligned)
  );

  assign retire_now = (state_reg == ISSUE) && retire;
  // Kernel code is never interrupted; the request waits for user mode.
  assign take_irq   = retire_now && irq_pending_reg && !pc_reg[31];

`ifdef PC_FETCH_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] timeout_cnt_reg;
  logic          timeout;
  assign timeout = (timeout_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      epc_reg         <= 32'd0;
      instruction_reg <= 32'd0;
      imem_req_reg    <= 1'b0;
      instr_valid_reg <= 1'b0;
      irq_taken_reg   <= 1'b0;
      addr_err_reg    <= 1'b0;
      irq_pending_reg <= 1'b0;
`ifdef PC_FETCH_TIMEOUT_EN
      timeout_cnt_reg <= '0;
`endif
    end else begin
      irq_taken_reg   <= 1'b0;
      addr_err_reg    <= 1'b0;
      // A request seen during the taking retire stays pending for the next one.
      irq_pending_reg <= IRQ | (irq_pending_reg & ~take_irq);
      case (state_reg)
        IDLE: begin
          state_reg    <= FETCH;
          imem_req_reg <= 1'b1;
`ifdef PC_FETCH_TIMEOUT_EN
          timeout_cnt_reg <= '0;
`endif
        end
        FETCH: begin
          if (imem_ack) begin
            instruction_reg <= imem_rdata;
            instr_valid_reg <= 1'b1;
            imem_req_reg    <= 1'b0;
            state_reg       <= ISSUE;
          end
`ifdef PC_FETCH_TIMEOUT_EN
          else if (timeout) begin
            imem_req_reg <= 1'b0;
            epc_reg      <= pc_reg;
            pc_reg       <= XADR_PC;
            addr_err_reg <= 1'b1;
            state_reg    <= IDLE;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + TW'(1);
          end
`endif
        end
        ISSUE: begin
          if (retire) begin
            instr_valid_reg <= 1'b0;
            imem_req_reg    <= 1'b1;
            state_reg       <= FETCH;
`ifdef PC_FETCH_TIMEOUT_EN
            timeout_cnt_reg <= '0;
`endif
            if (take_irq) begin
              pc_reg        <= ILLOP_PC;
              epc_reg       <= target;
              irq_taken_reg <= 1'b1;
            end else if (misaligned) begin
              pc_reg       <= XADR_PC;
              epc_reg      <= pc_plus4;
              addr_err_reg <= 1'b1;
            end else begin
              pc_reg <= target;
            end
          end
        end
        default: begin
          state_reg    <= IDLE;
          imem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_reg;
  assign imem_addr   = pc_reg;
  assign instruction = instruction_reg;
  assign instr_valid = instr_valid_reg;
  assign PC          = pc_reg;
  assign PC_plus4    = pc_plus4;
  assign EPC         = epc_reg;
  assign irq_taken   = irq_taken_reg;
  assign addr_err    = addr_err_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized
// retires checked against a behavioural model of the PC rules.
module tb_pc_fetch_unit;

  localparam logic [31:0] T_RESET = 32'h8000_0000;
  localparam logic [31:0] T_ILLOP = 32'h8000_0004;
  localparam logic [31:0] T_XADR  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  PCSrc;
  logic        BranchTaken;
  logic [31:0] ConBA;
  logic [25:0] JT;
  logic [31:0] DatabusA;
  logic        retire;
  logic        IRQ;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic [31:0] EPC;
  logic        irq_taken;
  logic        addr_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_pc, m_epc, m_instr;
  logic        m_pend;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .PCSrc       (PCSrc),
    .BranchTaken (BranchTaken),
    .ConBA       (ConBA),
    .JT          (JT),
    .DatabusA    (DatabusA),
    .retire      (retire),
    .IRQ         (IRQ),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .PC          (PC),
    .PC_plus4    (PC_plus4),
    .EPC         (EPC),
    .irq_taken   (irq_taken),
    .addr_err    (addr_err)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch one instruction: check the request, ack after 'delay' cycles.
  task automatic do_fetch(input logic [31:0] rdata, input int delay, input logic irq);
    int waited = 0;
    while (imem_req !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (imem_req !== 1'b1) $display("FAIL fetch_req: got %b expected 1", imem_req);
    else n_pass++;
    n_checks++;
    if (imem_addr !== m_pc) $display("FAIL fetch_addr: got %h expected %h", imem_addr, m_pc);
    else n_pass++;
    IRQ = irq;
    for (int i = 0; i < delay; i++) begin
      tick();
      IRQ = 1'b0;
    end
    if (delay > 0) begin
      n_checks++;
      if (instr_valid !== 1'b0) $display("FAIL valid_before_ack: got %b expected 0", instr_valid);
      else n_pass++;
    end
    imem_rdata = rdata;
    imem_ack   = 1'b1;
    tick();
    imem_ack   = 1'b0;
    IRQ        = 1'b0;
    imem_rdata = $urandom;
    if (irq) m_pend = 1'b1;
    m_instr = rdata;
    n_checks++;
    if (instr_valid !== 1'b1) $display("FAIL valid_after_ack: got %b expected 1", instr_valid);
    else n_pass++;
    n_checks++;
    if (instruction !== rdata) $display("FAIL instruction: got %h expected %h", instruction, rdata);
    else n_pass++;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL req_drop: got %b expected 0", imem_req);
    else n_pass++;
    n_checks++;
    if ({irq_taken, addr_err} !== 2'b00)
      $display("FAIL pulse_clear: got irq_taken=%b addr_err=%b expected 0 0", irq_taken, addr_err);
    else n_pass++;
  endtask

  // Hold one ISSUE cycle (with a stray ack), then retire and check the new PC.
  task automatic do_retire(input logic [2:0] src, input logic bt, input logic [31:0] cba,
                           input logic [25:0] jt, input logic [31:0] dba, input logic irq);
    logic [31:0] p4, tgt, e_pc, e_epc;
    logic        e_irq, e_err;
    p4 = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
    case (src)
      3'd0:    tgt = p4;
      3'd1:    tgt = bt ? ((cba & 32'h7FFF_FFFF) | (m_pc & 32'h8000_0000)) : p4;
      3'd2:    tgt = (m_pc & 32'hF000_0000) | (32'(jt) << 2);
      3'd3:    tgt = dba;
      3'd4:    tgt = T_ILLOP;
      default: tgt = T_XADR;
    endcase
    e_epc = m_epc;
    e_irq = 1'b0;
    e_err = 1'b0;
    if (m_pend && m_pc < 32'h8000_0000) begin
      e_pc = T_ILLOP; e_epc = tgt; e_irq = 1'b1; m_pend = 1'b0;
    end else if (src == 3'd3 && (dba % 4) != 0) begin
      e_pc = T_XADR; e_epc = p4; e_err = 1'b1;
    end else begin
      e_pc = tgt;
    end
    if (irq) m_pend = 1'b1;

    imem_ack   = 1'b1;
    imem_rdata = ~m_instr;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (instruction !== m_instr || instr_valid !== 1'b1)
      $display("FAIL issue_hold: got %h/%b expected %h/1", instruction, instr_valid, m_instr);
    else n_pass++;

    PCSrc = src; BranchTaken = bt; ConBA = cba; JT = jt; DatabusA = dba;
    retire = 1'b1;
    IRQ    = irq;
    tick();
    retire = 1'b0;
    IRQ    = 1'b0;
    PCSrc = 3'($urandom); BranchTaken = 1'($urandom); ConBA = $urandom; JT = 26'($urandom); DatabusA = $urandom;
    n_checks++;
    if (PC !== e_pc) $display("FAIL next_pc src=%0d: got %h expected %h", src, PC, e_pc);
    else n_pass++;
    n_checks++;
    if (EPC !== e_epc) $display("FAIL epc src=%0d: got %h expected %h", src, EPC, e_epc);
    else n_pass++;
    n_checks++;
    if (irq_taken !== e_irq) $display("FAIL irq_taken: got %b expected %b", irq_taken, e_irq);
    else n_pass++;
    n_checks++;
    if (addr_err !== e_err) $display("FAIL addr_err: got %b expected %b", addr_err, e_err);
    else n_pass++;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1)
      $display("FAIL retire_state: got valid=%b req=%b expected 0 1", instr_valid, imem_req);
    else n_pass++;
    n_checks++;
    if (PC_plus4 !== ((e_pc & 32'h8000_0000) | ((e_pc + 32'd4) & 32'h7FFF_FFFF)))
      $display("FAIL pc_plus4: got %h for PC %h", PC_plus4, e_pc);
    else n_pass++;
    m_pc  = e_pc;
    m_epc = e_epc;
  endtask

  task automatic test_reset();
    reset = 1'b0; PCSrc = 3'd0; BranchTaken = 1'b0; ConBA = 32'd0; JT = 26'd0;
    DatabusA = 32'd0; retire = 1'b0; IRQ = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    m_pc = T_RESET; m_epc = 32'd0; m_instr = 32'd0; m_pend = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (PC !== T_RESET) $display("FAIL reset_pc: got %h expected %h", PC, T_RESET);
    else n_pass++;
    n_checks++;
    if (EPC !== 32'd0 || instruction !== 32'd0)
      $display("FAIL reset_epc_instr: got %h/%h expected 0/0", EPC, instruction);
    else n_pass++;
    n_checks++;
    if ({imem_req, instr_valid, irq_taken, addr_err} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {imem_req, instr_valid, irq_taken, addr_err});
    else n_pass++;
    n_checks++;
    if (PC_plus4 !== 32'h8000_0004) $display("FAIL reset_pc_plus4: got %h expected 80000004", PC_plus4);
    else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== T_RESET)
      $display("FAIL first_req: got %b@%h expected 1@%h", imem_req, imem_addr, T_RESET);
    else n_pass++;
  endtask

  task automatic test_first_fetch();
    do_fetch(32'h2008_0005, 2, 1'b0);
  endtask

  task automatic test_branch();
    do_retire(3'd3, 1'b0, 32'd0, 26'd0, 32'h0040_0000, 1'b0); do_fetch($urandom, 1, 1'b0);
    do_retire(3'd1, 1'b1, 32'h8040_0010, 26'd0, 32'd0, 1'b0); do_fetch($urandom, 0, 1'b0);
    do_retire(3'd3, 1'b0, 32'd0, 26'd0, 32'h0040_0000, 1'b0); do_fetch($urandom, 1, 1'b0);
    do_retire(3'd1, 1'b0, 32'h8040_0010, 26'd0, 32'd0, 1'b0); do_fetch($urandom, 2, 1'b0);
    do_retire(3'd2, 1'b0, 32'd0, 26'h3FF_FFFF, 32'd0, 1'b0); do_fetch($urandom, 0, 1'b0);
  endtask

  task automatic test_kernel_jr();
    do_retire(3'd4, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0);        do_fetch($urandom, 1, 1'b0);
    do_retire(3'd2, 1'b0, 32'd0, 26'h40, 32'd0, 1'b0);       do_fetch($urandom, 0, 1'b0);
    do_retire(3'd3, 1'b0, 32'd0, 26'd0, 32'h0040_0020, 1'b0); do_fetch($urandom, 1, 1'b0);
    do_retire(3'd4, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0);        do_fetch($urandom, 0, 1'b0);
    do_retire(3'd2, 1'b0, 32'd0, 26'h40, 32'd0, 1'b0);       do_fetch($urandom, 1, 1'b0);
    do_retire(3'd3, 1'b0, 32'd0, 26'd0, 32'h0040_0022, 1'b0); do_fetch($urandom, 2, 1'b0);
  endtask

  task automatic test_irq();
    do_retire(3'd3, 1'b0, 32'd0, 26'd0, 32'h0040_0000, 1'b0); do_fetch($urandom, 1, 1'b1);
    do_retire(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0);        do_fetch($urandom, 2, 1'b1);
    do_retire(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0);        do_fetch($urandom, 1, 1'b0);
    do_retire(3'd3, 1'b0, 32'd0, 26'd0, 32'h0040_0100, 1'b0); do_fetch($urandom, 0, 1'b0);
    do_retire(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0);        do_fetch($urandom, 1, 1'b0);
    do_retire(3'd3, 1'b0, 32'd0, 26'd0, 32'h0040_0200, 1'b0); do_fetch($urandom, 1, 1'b0);
    do_retire(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b1);        do_fetch($urandom, 1, 1'b0);
    do_retire(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0);        do_fetch($urandom, 1, 1'b0);
  endtask

  task automatic test_wrap();
    do_retire(3'd3, 1'b0, 32'd0, 26'd0, 32'h7FFF_FFFC, 1'b0); do_fetch($urandom, 0, 1'b0);
    do_retire(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0);        do_fetch($urandom, 1, 1'b0);
    do_retire(3'd3, 1'b0, 32'd0, 26'd0, 32'hFFFF_FFFC, 1'b0); do_fetch($urandom, 0, 1'b0);
    do_retire(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0);        do_fetch($urandom, 1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] dba;
    for (int i = 0; i < 40; i++) begin
      dba = $urandom;
      if ($urandom_range(3) != 0) dba[1:0] = 2'b00;
      do_retire(3'($urandom_range(7)), 1'($urandom), $urandom, 26'($urandom), dba,
                $urandom_range(7) == 0);
      do_fetch($urandom, int'($urandom_range(3)), $urandom_range(5) == 0);
    end
  endtask

`ifdef PC_FETCH_TIMEOUT_EN
  task automatic test_timeout();
    do_retire(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0);
    repeat (15) tick();
    n_checks++;
    if (imem_req !== 1'b1 || addr_err !== 1'b0)
      $display("FAIL timeout_early: got req=%b err=%b expected 1 0", imem_req, addr_err);
    else n_pass++;
    tick();
    n_checks++;
    if (PC !== T_XADR || EPC !== m_pc || addr_err !== 1'b1 || imem_req !== 1'b0)
      $display("FAIL timeout_trap: got PC=%h EPC=%h err=%b req=%b expected %h %h 1 0",
               PC, EPC, addr_err, imem_req, T_XADR, m_pc);
    else n_pass++;
    m_epc = m_pc;
    m_pc  = T_XADR;
    do_fetch($urandom, 1, 1'b0);
  endtask
`endif

  task automatic test_reset_mid_fetch();
    do_retire(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0);
    reset = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL reset_async_req: got %b expected 0", imem_req);
    else n_pass++;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (2) tick();
    imem_ack = 1'b0;
    n_checks++;
    if (PC !== T_RESET || instr_valid !== 1'b0 || instruction !== 32'd0 || imem_req !== 1'b0)
      $display("FAIL reset_mid_fetch: got PC=%h valid=%b instr=%h req=%b expected %h 0 0 0",
               PC, instr_valid, instruction, imem_req, T_RESET);
    else n_pass++;
    m_pc = T_RESET; m_epc = 32'd0; m_pend = 1'b0;
    reset = 1'b1;
    do_fetch(32'h2008_0005, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_branch();
    test_kernel_jr();
    test_irq();
    test_wrap();
    test_random();
`ifdef PC_FETCH_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
